mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 256x32 memory (word/bit/byte read opcodes) among NREQ requesters.
//  Accepts one command at a time, drives the memory's WrEn/RdEn/RdEn_Opcode/Addr/BitAddr/ByteAddr/WrBus,
//  waits the memory read latency and returns RdBus to the owning requester with a valid pulse.
//  Sits between client blocks (test/host agents) and the memory instance.
// PARAMETERS
//  NREQ    2   number of requesters (1..8)
//  RD_LAT  2   cycles from RdEn asserted to RdBus valid at memory output (>=1)
// PORTS
//  clk          in   1          single clock, rising edge
//  reset        in   1          synchronous, active-high
//  req          in   NREQ       request valid per requester; held until ack
//  req_we       in   NREQ       1=write, 0=read
//  req_op       in   NREQ x 2   read opcode: 0=word, 1=bit, 2=byte, 3=reserved
//  req_addr     in   NREQ x 8   word address
//  req_bitaddr  in   NREQ x 5   bit select (op=1)
//  req_byteaddr in   NREQ x 2   byte select (op=2)
//  req_wdata    in   NREQ x 32  write data
//  ack          out  NREQ       1-cycle pulse: command accepted and driven to memory
//  rvalid       out  NREQ       1-cycle pulse: rdata valid for that requester
//  rdata        out  32         read data (shared, qualify with rvalid)
//  busy         out  1          high in any state but IDLE
//  WrEn,RdEn    out  1          memory strobes
//  RdEn_Opcode  out  2          memory opcode
//  Addr out 8; BitAddr out 5; ByteAddr out 2; WrBus out 32   memory command
//  RdBus        in   32         memory read data
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr_ptr=0, owner=0, any in-flight read dropped (no rvalid).
//  FSM: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> RESP -> IDLE.
//   IDLE: if |req, winner = first set bit searching from rr_ptr upward (wrapping NREQ-1->0);
//     capture winner's command into regs, owner<=winner, rr_ptr<=winner+1 mod NREQ, go ISSUE.
//   ISSUE (1 cycle): memory command regs drive outputs; WrEn=req_we, RdEn=~req_we; ack[owner]=1.
//     Write -> IDLE. Read -> WAIT, load wait counter with RD_LAT-1.
//   WAIT: WrEn=RdEn=0, command outputs hold; counter decrements; at 0 -> RESP.
//   RESP: rdata<=RdBus registered, rvalid[owner]=1 next cycle coincident with return to IDLE.
//  Timing: write = req seen in IDLE cycle N, ack/WrEn cycle N+1, next arbitration N+2.
//   Read = ack/RdEn cycle N+1, rvalid cycle N+2+RD_LAT; rdata holds until next read.
//  Only one outstanding command; new requests wait (req stays high, no ack) while busy.
//  req dropped before ack: not granted, no error. Requests arriving during busy arbitrate in next IDLE.
//  op=3: forwarded unchanged to memory; rdata is whatever memory returns.
//  Writes ignore req_op/bitaddr/byteaddr (forwarded, don't-care).
//  Reset in any state: immediate return to IDLE next edge, no ack/rvalid emitted that cycle.
//  ack and rvalid are one-hot or zero; never two requesters flagged same cycle.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum {IDLE,ISSUE,WAIT,RESP} arb_state_t; typedef enum logic[1:0]
//   {OP_WORD=0,OP_BIT=1,OP_BYTE=2,OP_RSVD=3} rd_op_t; struct mem_cmd_t {we,op,addr,bitaddr,byteaddr,wdata}.
//  Sub-module rr_picker (NREQ-wide round-robin priority select: req, ptr -> one-hot grant + index).
// TESTING (bench instantiates arbiter + memory, golden_array model, StudentId tied)
//  1 Reset: reset=1 3 cycles with req=all 1 -> ack=0, rvalid=0, WrEn=RdEn=0, busy=0 throughout.
//  2 Single write/read: req0 write addr=8'h10 wdata=32'hDEADBEEF, then read op=0 addr=8'h10 ->
//     ack0 at N+1, rvalid0 exactly RD_LAT+1 cycles after read ack, rdata=32'hDEADBEEF.
//  3 Contention: req0,req1 both held reading addr 1/2 -> grants alternate 0,1,0,1 (rr_ptr=0 after reset);
//     rvalid never to non-owner; requester 1 write of 32'h5 to addr 2 while 0 reads: no starvation.
//  4 Byte/bit reads: addr=8'h20 holds 32'hA5C3_0F81; op=2 byteaddr=2 -> rdata[7:0]=8'hC3;
//     op=1 bitaddr=7 -> rdata[0]=1 (bit per memory's bit-read definition, checked vs golden).
//  5 Reset mid-read: assert reset during WAIT -> no rvalid, busy=0 next cycle; subsequent read returns correct data.
//  6 Soak: 500 random cmds from both requesters (random addr/op/data) -> every ack'd read matches golden_array.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory access arbiter.
//   arb_state_t : arbiter sequencing states
//   rd_op_t     : memory read opcode (word / bit / byte / reserved)
//   mem_cmd_t   : one captured memory command
//   idx_width() : index width for an N-entry one-hot vector (min 1)
package mem_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int BIT_W   = 5;
    localparam int BYTE_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_WORD = 2'd0,
        OP_BIT  = 2'd1,
        OP_BYTE = 2'd2,
        OP_RSVD = 2'd3
    } rd_op_t;

    typedef struct packed {
        logic              we;
        rd_op_t            op;
        logic [ADDR_W-1:0] addr;
        logic [BIT_W-1:0]  bitaddr;
        logic [BYTE_W-1:0] byteaddr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_picker.sv
// Round-robin priority select.
//   req       : request vector
//   ptr       : highest-priority index for this pick
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted requester
//   any       : at least one request present
module rr_picker import mem_arb_pkg::*; #(
    parameter int NREQ = 2,
    parameter int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any
);

    // First pass searches ptr..NREQ-1, second pass wraps to 0..ptr-1;
    // the second pass can only win when the first found nothing.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (j >= 32'(ptr))) begin
                grant[j]  = 1'b1;
                grant_idx = IDXW'(j);
                any       = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDXW'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one 256x32 memory among NREQ
// requesters. One command in flight at a time; reads wait RD_LAT cycles
// and return data with a one-cycle rvalid pulse to the owning requester.
//   clk, reset          : clock, synchronous active-high reset
//   req/req_we/req_op/req_addr/req_bitaddr/req_byteaddr/req_wdata
//                       : per-requester command, req held until ack
//   ack                 : one-hot pulse, command driven to memory
//   rvalid, rdata       : one-hot read-return pulse, shared read data
//   busy                : arbiter not idle
//   WrEn, RdEn, RdEn_Opcode, Addr, BitAddr, ByteAddr, WrBus : memory command
//   RdBus               : memory read data
module mem_access_arbiter import mem_arb_pkg::*; #(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              req_we,
    input  logic [NREQ-1:0][1:0]         req_op,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NREQ-1:0][BIT_W-1:0]   req_bitaddr,
    input  logic [NREQ-1:0][BYTE_W-1:0]  req_byteaddr,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NREQ-1:0]              ack,
    output logic [NREQ-1:0]              rvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         busy,
    output logic                         WrEn,
    output logic                         RdEn,
    output logic [1:0]                   RdEn_Opcode,
    output logic [ADDR_W-1:0]            Addr,
    output logic [BIT_W-1:0]             BitAddr,
    output logic [BYTE_W-1:0]            ByteAddr,
    output logic [DATA_W-1:0]            WrBus,
    input  logic [DATA_W-1:0]            RdBus
);

    localparam int IDXW = idx_width(NREQ);
    localparam int CNTW = idx_width(RD_LAT);

    arb_state_t        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [NREQ-1:0]   owner_q, owner_d;      // one-hot owner of the command
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;

    logic [NREQ-1:0]   pick_grant;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_any;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req       (req),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    cmd_d.we       = req_we[pick_idx];
                    cmd_d.op       = rd_op_t'(req_op[pick_idx]);
                    cmd_d.addr     = req_addr[pick_idx];
                    cmd_d.bitaddr  = req_bitaddr[pick_idx];
                    cmd_d.byteaddr = req_byteaddr[pick_idx];
                    cmd_d.wdata    = req_wdata[pick_idx];
                    owner_d        = pick_grant;
                    rr_ptr_d       = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_q.we) begin
                    state_d = IDLE;
                end else begin
                    // RESP must land on the cycle RdBus is valid (RD_LAT after
                    // ISSUE), so WAIT lasts RD_LAT-1 cycles and is skipped
                    // entirely when RD_LAT is 1.
                    cnt_d   = CNTW'(RD_LAT - 1);
                    state_d = (RD_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata_d  = RdBus;
                rvalid_d = owner_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; everything is forced low while reset is asserted so an
    // in-progress ISSUE or pending rvalid never escapes in the reset cycle.
    always_comb begin
        ack         = '0;
        rvalid      = '0;
        busy        = 1'b0;
        WrEn        = 1'b0;
        RdEn        = 1'b0;
        RdEn_Opcode = '0;
        Addr        = '0;
        BitAddr     = '0;
        ByteAddr    = '0;
        WrBus       = '0;
        rdata       = '0;
        if (!reset) begin
            busy        = (state_q != IDLE);
            rvalid      = rvalid_q;
            rdata       = rdata_q;
            RdEn_Opcode = cmd_q.op;
            Addr        = cmd_q.addr;
            BitAddr     = cmd_q.bitaddr;
            ByteAddr    = cmd_q.byteaddr;
            WrBus       = cmd_q.wdata;
            if (state_q == ISSUE) begin
                ack  = owner_q;
                WrEn = cmd_q.we;
                RdEn = ~cmd_q.we;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: behavioural 256x32 memory with RD_LAT read
// pipeline, golden array updated on write acks, read scoreboard checked on
// rvalid (data, owner and latency).
module tb_mem_access_arbiter;

    localparam int NREQ   = 2;
    localparam int RD_LAT = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   mem_clear;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ-1:0][1:0]   req_op;
    logic [NREQ-1:0][7:0]   req_addr;
    logic [NREQ-1:0][4:0]   req_bitaddr;
    logic [NREQ-1:0][1:0]   req_byteaddr;
    logic [NREQ-1:0][31:0]  req_wdata;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        rvalid;
    logic [31:0]            rdata;
    logic                   busy;
    logic                   WrEn, RdEn;
    logic [1:0]             RdEn_Opcode;
    logic [7:0]             Addr;
    logic [4:0]             BitAddr;
    logic [1:0]             ByteAddr;
    logic [31:0]            WrBus;
    logic [31:0]            RdBus;

    // per-requester drive variables, written by independent driver processes
    logic        t_req   [NREQ];
    logic        t_we    [NREQ];
    logic [1:0]  t_op    [NREQ];
    logic [7:0]  t_addr  [NREQ];
    logic [4:0]  t_bit   [NREQ];
    logic [1:0]  t_byte  [NREQ];
    logic [31:0] t_wdata [NREQ];

    always_comb begin
        req = '0; req_we = '0; req_op = '0; req_addr = '0;
        req_bitaddr = '0; req_byteaddr = '0; req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]          = t_req[i];
            req_we[i]       = t_we[i];
            req_op[i]       = t_op[i];
            req_addr[i]     = t_addr[i];
            req_bitaddr[i]  = t_bit[i];
            req_byteaddr[i] = t_byte[i];
            req_wdata[i]    = t_wdata[i];
        end
    end

    mem_access_arbiter #(
        .NREQ   (NREQ),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_bitaddr  (req_bitaddr),
        .req_byteaddr (req_byteaddr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .busy         (busy),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .RdEn_Opcode  (RdEn_Opcode),
        .Addr         (Addr),
        .BitAddr      (BitAddr),
        .ByteAddr     (ByteAddr),
        .WrBus        (WrBus),
        .RdBus        (RdBus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory read formatting: bit read returns the selected bit in [0],
    // byte read returns the selected byte in [7:0], reserved returns the word
    function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [1:0] op,
                                           input logic [4:0] b, input logic [1:0] y);
        case (op)
            2'd0:    return w;
            2'd1:    return {31'b0, w[b]};
            2'd2:    return {24'b0, w[8*y +: 8]};
            default: return w;
        endcase
    endfunction

    // behavioural memory
    logic [31:0] mem    [256];
    logic [31:0] pipe_d [RD_LAT];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (WrEn) begin
            mem[Addr] <= WrBus;
        end
        pipe_d[0] <= RdEn ? rd_fmt(mem[Addr], RdEn_Opcode, BitAddr, ByteAddr) : 32'h0;
        for (int k = 1; k < RD_LAT; k++) pipe_d[k] <= pipe_d[k-1];
    end
    assign RdBus = pipe_d[RD_LAT-1];

    // checking
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          r;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [31:0] golden [256];

    task automatic do_cmd(input int r, input logic we, input logic [1:0] op,
                          input logic [7:0] addr, input logic [4:0] b, input logic [1:0] y,
                          input logic [31:0] wd, output int waited);
        @(negedge clk);
        t_we[r] = we; t_op[r] = op; t_addr[r] = addr;
        t_bit[r] = b; t_byte[r] = y; t_wdata[r] = wd;
        t_req[r] = 1'b1;
        waited = 0;
        while (1) begin
            @(negedge clk);
            waited++;
            if (ack[r]) begin
                t_req[r] = 1'b0;
                grant_log.push_back(r);
                if (we) golden[addr] = wd;
                else    sb.push_back('{r, rd_fmt(golden[addr], op, b, y), cyc + RD_LAT + 1});
                break;
            end
            if (waited >= 200) begin
                check_eq($sformatf("ack_bound_r%0d", r), 32'(ack[r]), 32'd1);
                t_req[r] = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (sb.size() != 0 || busy); k++) @(negedge clk);
        check_eq("drained", sb.size(), 0);
    endtask

    // rvalid monitor / scoreboard pop
    exp_t e;
    always @(negedge clk) begin
        if (ack != '0) check_eq("ack_onehot", 32'($onehot0(ack)), 32'd1);
        if (rvalid != '0) begin
            check_eq("rvalid_onehot", 32'($onehot0(rvalid)), 32'd1);
            if (sb.size() == 0) begin
                check_eq("rvalid_unexpected", 32'(rvalid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("rvalid_owner", 32'(rvalid), 32'd1 << e.r);
                check_eq("rdata", rdata, e.data);
                check_eq("rvalid_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int w, w1, k;

    initial begin
        reset = 1'b1;
        mem_clear = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            t_req[i] = 1'b1; t_we[i] = 1'b0; t_op[i] = '0; t_addr[i] = '0;
            t_bit[i] = '0; t_byte[i] = '0; t_wdata[i] = '0;
        end
        for (int i = 0; i < 256; i++) golden[i] = '0;

        // 1: reset with all requests asserted
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_ack",    32'(ack),    32'd0);
            check_eq("rst_rvalid", 32'(rvalid), 32'd0);
            check_eq("rst_wren",   32'(WrEn),   32'd0);
            check_eq("rst_rden",   32'(RdEn),   32'd0);
            check_eq("rst_busy",   32'(busy),   32'd0);
        end
        for (int i = 0; i < NREQ; i++) t_req[i] = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // 2: single write then read back
        do_cmd(0, 1'b1, 2'd0, 8'h10, 5'd0, 2'd0, 32'hDEADBEEF, w);
        check_eq("wr_ack_lat", w, 1);
        do_cmd(0, 1'b0, 2'd0, 8'h10, 5'd0, 2'd0, 32'h0, w);
        check_eq("rd_ack_lat", w, 1);
        drain();
        check_eq("rd_word", rdata, 32'hDEADBEEF);

        // 3: contention, round robin from pointer 0 after reset
        do_cmd(0, 1'b1, 2'd0, 8'h01, 5'd0, 2'd0, 32'h1111_1111, w);
        do_cmd(1, 1'b1, 2'd0, 8'h02, 5'd0, 2'd0, 32'h2222_2222, w);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        grant_log.delete();
        fork
            begin repeat (4) do_cmd(0, 1'b0, 2'd0, 8'h01, 5'd0, 2'd0, 32'h0, w); end
            begin repeat (4) do_cmd(1, 1'b0, 2'd0, 8'h02, 5'd0, 2'd0, 32'h0, w1); end
        join
        drain();
        check_eq("grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check_eq($sformatf("grant_order_%0d", i), grant_log[i], i % 2);
        fork
            begin repeat (3) do_cmd(0, 1'b0, 2'd0, 8'h02, 5'd0, 2'd0, 32'h0, w); end
            begin
                do_cmd(1, 1'b1, 2'd0, 8'h02, 5'd0, 2'd0, 32'h5, w1);
                check_eq("r1_write_wait", 32'(w1 <= 8), 32'd1);
            end
        join
        drain();
        do_cmd(0, 1'b0, 2'd0, 8'h02, 5'd0, 2'd0, 32'h0, w);
        drain();
        check_eq("addr2_after_write", rdata, 32'h5);

        // 4: byte / bit / reserved reads
        do_cmd(1, 1'b1, 2'd0, 8'h20, 5'd0, 2'd0, 32'hA5C3_0F81, w);
        do_cmd(0, 1'b0, 2'd2, 8'h20, 5'd0, 2'd2, 32'h0, w);
        drain();
        check_eq("byte2", 32'(rdata[7:0]), 32'hC3);
        do_cmd(1, 1'b0, 2'd1, 8'h20, 5'd7, 2'd0, 32'h0, w);
        drain();
        check_eq("bit7", 32'(rdata[0]), 32'd1);
        do_cmd(0, 1'b0, 2'd1, 8'h20, 5'd4, 2'd0, 32'h0, w);
        do_cmd(1, 1'b0, 2'd2, 8'h20, 5'd0, 2'd3, 32'h0, w);
        do_cmd(0, 1'b0, 2'd3, 8'h20, 5'd0, 2'd0, 32'h0, w);
        drain();

        // 5: reset while waiting on a read
        @(negedge clk);
        t_we[0] = 1'b0; t_op[0] = 2'd0; t_addr[0] = 8'h20; t_req[0] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!ack[0] && k < 50);
        check_eq("rst_rd_ack", 32'(ack[0]), 32'd1);
        t_req[0] = 1'b0;
        @(negedge clk);
        check_eq("busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("busy_after_rst", 32'(busy), 32'd0);
        repeat (4) begin
            check_eq("no_rvalid_after_rst", 32'(rvalid), 32'd0);
            @(negedge clk);
        end
        do_cmd(0, 1'b0, 2'd0, 8'h20, 5'd0, 2'd0, 32'h0, w);
        drain();
        check_eq("rd_after_rst", rdata, 32'hA5C3_0F81);

        // 6: random soak from both requesters
        fork
            begin
                int wa;
                repeat (250)
                    do_cmd(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           8'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                           2'($urandom_range(0, 3)), $urandom, wa);
            end
            begin
                int wb;
                repeat (250)
                    do_cmd(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           8'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                           2'($urandom_range(0, 3)), $urandom, wb);
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
